tpu_sequencer: RTL

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/seq_cnt.sv | 32 +++
 rtl/tpu_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg -- shared definitions for the TPU job sequencer.
//   seq_state_t : sequencer state encoding
//   calc_l      : serial operand load length L = N*N*D_W (cycles)
//   max_int     : helper for sizing the shared down-counter
package tpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_GAP     = 3'd2,
      S_XFER    = 3'd3,
      S_COMPUTE = 3'd4,
      S_DONE    = 3'd5
   } seq_state_t;

   function automatic int calc_l(input int n, input int d_w);
      return n * n * d_w;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_cnt.sv
// seq_cnt -- loadable down-counter shared by the LOAD and COMPUTE phases.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero (no wrap-around)
//   zero      : count is zero
module seq_cnt #(
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - CW'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/tpu_sequencer.sv
// tpu_sequencer -- control FSM for one load / transfer / compute job of an
// N x N systolic array with D_W-bit operands.
// Sequence: IDLE -> LOAD (L cycles) -> GAP -> XFER -> COMPUTE (COMP_LAT
// cycles, skipped when COMP_LAT=0) -> DONE -> IDLE.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   abort    : (only with SEQ_ABORT_EN defined) return to IDLE from any
//              busy state, no done pulse
//   start    : job request, sampled only in IDLE
//   ready    : high in IDLE
//   load_en  : operand loader enable, high for L cycles per job
//   bit_req  : host serial-bit request, identical to load_en
//   acc_clr  : one-cycle accumulator clear (GAP)
//   init     : one-cycle operand transfer pulse (XFER)
//   busy     : high outside IDLE
//   done     : one-cycle result-valid pulse
// Optional feature macro: SEQ_ABORT_EN.
module tpu_sequencer
   import tpu_pkg::*;
#(
   parameter int D_W      = 8,
   parameter int N        = 2,
   parameter int COMP_LAT = 3*N-1
) (
   input  logic clk,
   input  logic rst,
`ifdef SEQ_ABORT_EN
   input  logic abort,
`endif
   input  logic start,
   output logic ready,
   output logic load_en,
   output logic bit_req,
   output logic init,
   output logic acc_clr,
   output logic busy,
   output logic done
);

   localparam int L  = calc_l(N, D_W);
   localparam int CW = $clog2(max_int(L, COMP_LAT) + 1);
   // Counter holds (remaining cycles - 1) so the zero flag marks the last
   // cycle of a phase and the transition lands exactly after it.
   localparam logic [CW-1:0] LOAD_LD = CW'(L - 1);
   localparam logic [CW-1:0] COMP_LD = (COMP_LAT > 0) ? CW'(COMP_LAT - 1) : '0;
   localparam bit            HAS_COMP = (COMP_LAT > 0);

   seq_state_t    state, nxt;
   logic          cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_val;
   logic          abort_i;

`ifdef SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   seq_cnt #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_val  = LOAD_LD;
      cnt_dec  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               nxt      = S_LOAD;
               cnt_load = 1'b1;
               cnt_val  = LOAD_LD;
            end
         end
         S_LOAD: begin
            if (cnt_zero) nxt = S_GAP;
            else          cnt_dec = 1'b1;
         end
         S_GAP:  nxt = S_XFER;
         S_XFER: begin
            if (HAS_COMP) begin
               nxt      = S_COMPUTE;
               cnt_load = 1'b1;
               cnt_val  = COMP_LD;
            end else begin
               nxt = S_DONE;
            end
         end
         S_COMPUTE: begin
            if (cnt_zero) nxt = S_DONE;
            else          cnt_dec = 1'b1;
         end
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (abort_i && (state != S_IDLE)) begin
         nxt      = S_IDLE;
         cnt_load = 1'b0;
         cnt_dec  = 1'b0;
      end
   end

   // Outputs decoded from the next state so they align with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         load_en <= 1'b0;
         acc_clr <= 1'b0;
         init    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= nxt;
         ready   <= (nxt == S_IDLE);
         busy    <= (nxt != S_IDLE);
         load_en <= (nxt == S_LOAD);
         acc_clr <= (nxt == S_GAP);
         init    <= (nxt == S_XFER);
         done    <= (nxt == S_DONE);
      end
   end

   assign bit_req = load_en;

endmodule
